// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesting units (master) and the
// round-robin arbiter (slave).
interface rr_decoder_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic [7:0] gnt;
    logic       timeout;

    modport master (output req, done, input gnt_idx, gnt_en, gnt, timeout);
    modport slave  (input req, done, output gnt_idx, gnt_en, gnt, timeout);
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Eight-way round-robin arbiter driving a 3-to-8 one-hot grant decode.
// Optional hold-limit forced release is compiled in with RR_TIMEOUT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate from ptr upward when any req is set
// GRANT | gnt_idx owns the resource until done, withdrawal or hold limit
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_decoder_arbiter_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    logic [0:0] state;
    logic [2:0] ptr;
    logic [2:0] idx_q;
    logic       en_q;
    logic [2:0] pick;
    logic [2:0] cand;
    logic       owner_rel;
    logic       hold_exp;
    logic [7:0] gnt_dec;

    // Scan offsets high to low so the nearest set bit above ptr wins.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr + 3'(k);
            if (bus.req[cand]) pick = cand;
        end
    end

    assign owner_rel = bus.done || !bus.req[idx_q];

`ifdef RR_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       to_q;
    // Down-counter loaded on grant; terminal count 0 marks the last allowed cycle.
    assign hold_exp    = (hold_cnt == 8'd0);
    assign bus.timeout = to_q;
`else
    assign hold_exp    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd0;
            idx_q <= 3'd0;
            en_q  <= 1'b0;
`ifdef RR_TIMEOUT_EN
            hold_cnt <= 8'd0;
            to_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef RR_TIMEOUT_EN
                    to_q <= 1'b0;
`endif
                    if (|bus.req) begin
                        idx_q <= pick;
                        en_q  <= 1'b1;
                        state <= GRANT;
`ifdef RR_TIMEOUT_EN
                        hold_cnt <= 8'(MAX_HOLD - 1);
`endif
                    end
                end
                GRANT: begin
                    if (owner_rel || hold_exp) begin
                        en_q  <= 1'b0;
                        ptr   <= idx_q + 3'd1;
                        state <= IDLE;
`ifdef RR_TIMEOUT_EN
                        // A voluntary release in the expiry cycle is not a timeout.
                        to_q <= !owner_rel;
`endif
                    end else begin
`ifdef RR_TIMEOUT_EN
                        hold_cnt <= hold_cnt - 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_dec = 8'h00;
        if (en_q) gnt_dec[idx_q] = 1'b1;
    end

    assign bus.gnt_idx = idx_q;
    assign bus.gnt_en  = en_q;
    assign bus.gnt     = gnt_dec;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed-vector bench for rr_decoder_arbiter; the timeout scenario runs
// only when RR_TIMEOUT_EN is defined, otherwise indefinite hold is checked.
module tb_rr_decoder_arbiter;
    logic clk;
    logic rst;
    int   vec;
    int   errs;

    rr_decoder_arbiter_if bus ();

    rr_decoder_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (bus.gnt !== 8'h00) begin errs++; $display("FAIL reset_gnt got %h want 00", bus.gnt); end
        vec++; if (bus.gnt_en !== 1'b0) begin errs++; $display("FAIL reset_gnt_en got %b want 0", bus.gnt_en); end
        vec++; if (bus.gnt_idx !== 3'd0) begin errs++; $display("FAIL reset_gnt_idx got %0d want 0", bus.gnt_idx); end
        vec++; if (bus.timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            bus.done = (i == 4);
            step();
            vec++;
            if ({bus.gnt, bus.gnt_en, bus.timeout} !== 10'b0) begin
                errs++;
                $display("FAIL idle cyc %0d gnt %h en %b to %b want 00 0 0", i, bus.gnt, bus.gnt_en, bus.timeout);
            end
        end
        bus.done = 1'b0;
    endtask

    task automatic test_basic();
        bus.req = 8'b0010_0100;
        step();
        vec++; if (bus.gnt_idx !== 3'd2) begin errs++; $display("FAIL basic_idx2 got %0d want 2", bus.gnt_idx); end
        vec++; if (bus.gnt !== 8'h04) begin errs++; $display("FAIL basic_gnt04 got %h want 04", bus.gnt); end
        step();
        vec++; if (bus.gnt !== 8'h04) begin errs++; $display("FAIL basic_hold got %h want 04", bus.gnt); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        vec++; if ({bus.gnt, bus.gnt_en} !== 9'h000) begin errs++; $display("FAIL basic_gap gnt %h en %b want 00 0", bus.gnt, bus.gnt_en); end
        vec++; if (bus.gnt_idx !== 3'd2) begin errs++; $display("FAIL basic_idx_kept got %0d want 2", bus.gnt_idx); end
        step();
        vec++; if (bus.gnt_idx !== 3'd5) begin errs++; $display("FAIL basic_idx5 got %0d want 5", bus.gnt_idx); end
        vec++; if (bus.gnt !== 8'h20) begin errs++; $display("FAIL basic_gnt20 got %h want 20", bus.gnt); end
    endtask

    task automatic test_wrap_withdraw();
        bus.done = 1'b1;
        bus.req  = 8'b0000_0011;
        step();
        bus.done = 1'b0;
        vec++; if (bus.gnt !== 8'h00) begin errs++; $display("FAIL wrap_gap got %h want 00", bus.gnt); end
        step();
        vec++; if (bus.gnt !== 8'h01) begin errs++; $display("FAIL wrap_gnt01 got %h want 01", bus.gnt); end
        bus.req = 8'b0000_0010;
        step();
        vec++; if (bus.gnt !== 8'h00) begin errs++; $display("FAIL withdraw_gap got %h want 00", bus.gnt); end
        step();
        vec++; if (bus.gnt !== 8'h02) begin errs++; $display("FAIL withdraw_gnt02 got %h want 02", bus.gnt); end
        bus.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_gnt;
        int         exp_idx;
        do_reset();
        bus.req = 8'hFF;
        exp_idx = 0;
        for (int g = 0; g < 10; g++) begin
            step();
            exp_gnt = 8'h01 << exp_idx;
            vec++;
            if (bus.gnt !== exp_gnt) begin errs++; $display("FAIL rr_grant %0d got %h want %h", g, bus.gnt, exp_gnt); end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            vec++;
            if (bus.gnt !== 8'h00) begin errs++; $display("FAIL rr_gap %0d got %h want 00", g, bus.gnt); end
            exp_idx = (exp_idx + 1) % 8;
        end
        bus.req = 8'h00;
        step();
    endtask

    task automatic test_hold_limit();
        do_reset();
        bus.req = 8'h08;
`ifdef RR_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            step();
            vec++;
            if ({bus.gnt, bus.timeout} !== {8'h08, 1'b0}) begin
                errs++; $display("FAIL to_hold cyc %0d gnt %h to %b want 08 0", c, bus.gnt, bus.timeout);
            end
        end
        step();
        vec++; if ({bus.gnt, bus.gnt_en, bus.timeout} !== {8'h00, 1'b0, 1'b1}) begin
            errs++; $display("FAIL to_pulse gnt %h en %b to %b want 00 0 1", bus.gnt, bus.gnt_en, bus.timeout);
        end
        step();
        vec++; if ({bus.gnt, bus.timeout} !== {8'h08, 1'b0}) begin
            errs++; $display("FAIL to_regrant gnt %h to %b want 08 0", bus.gnt, bus.timeout);
        end
        step();
        step();
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        vec++; if ({bus.gnt, bus.timeout} !== {8'h00, 1'b0}) begin
            errs++; $display("FAIL to_done_at_limit gnt %h to %b want 00 0", bus.gnt, bus.timeout);
        end
`else
        for (int c = 0; c < 20; c++) begin
            step();
            vec++;
            if ({bus.gnt, bus.timeout} !== {8'h08, 1'b0}) begin
                errs++; $display("FAIL hold_forever cyc %0d gnt %h to %b want 08 0", c, bus.gnt, bus.timeout);
            end
        end
`endif
        bus.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_async_reset();
        bus.req = 8'h10;
        step();
        vec++; if (bus.gnt !== 8'h10) begin errs++; $display("FAIL ar_pre got %h want 10", bus.gnt); end
        #2;
        rst = 1'b1;
        #1;
        vec++; if ({bus.gnt, bus.gnt_en} !== 9'h000) begin
            errs++; $display("FAIL ar_immediate gnt %h en %b want 00 0", bus.gnt, bus.gnt_en);
        end
        #1;
        rst = 1'b0;
        step();
        vec++; if (bus.gnt !== 8'h10) begin errs++; $display("FAIL ar_post got %h want 10", bus.gnt); end
        bus.req = 8'h00;
        step();
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        rst  = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        test_reset();
        test_idle();
        test_basic();
        test_wrap_withdraw();
        test_back_to_back();
        test_hold_limit();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

- Round-robin arbiter that shares one 3-to-8 one-hot select path among eight requesters.
- Picks one requester, then drives its 3-bit index and enable into a 3-to-8 decode to produce a one-hot grant vector.
- Holds the grant until the owner releases it, or until a hold limit expires when that feature is compiled in.
- Sits between requesting units and the shared resource they take turns using.

## Interface
Parameters:
- MAX_HOLD, default 15: maximum cycles a grant may be held (only used with RR_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  input  1  sole clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- done  input  1  owner releases the grant; single-cycle pulse.
- gnt_idx  output  3  index of the current owner.
- gnt_en  output  1  a grant is active.
- gnt  output  8  one-hot grant; decode of gnt_idx when gnt_en=1, else 8'h00.
- timeout  output  1  one-cycle pulse marking a forced release.

## Operation
- Reset (async, immediate):
  - gnt_idx=0, gnt_en=0, gnt=8'h00, timeout=0.
  - Internal pointer ptr=0, hold counter=0, state IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, search upward from ptr, wrapping 7→0.
  - Register the first set bit as gnt_idx, set gnt_en=1, clear the hold counter, go to GRANT.
  - If req == 0, stay in IDLE with outputs at 0.
- GRANT:
  - The owner is released when any of these holds: done=1, req[gnt_idx]=0 (owner withdraws), or a timeout (see Configuration).
  - On release: gnt_en=0, ptr=gnt_idx+1 mod 8 (7 wraps to 0), go to IDLE. gnt_idx keeps its last value.
  - Changes to other req bits during GRANT are ignored; no preemption.
  - done and a withdrawal in the same cycle count as one release.
- done while in IDLE is ignored.
- gnt is purely combinational from the registered gnt_idx and gnt_en. It is never multi-hot and never nonzero when gnt_en=0.

## Timing
- Grant latency: req sampled at edge N gives gnt valid after edge N, i.e. 1 cycle.
- Release: done sampled at edge M gives gnt=8'h00 after edge M.
- Break-before-make:
  - At least one cycle with gnt=8'h00 between successive grants.
  - Next grant is earliest after edge M+1.
- Back-to-back sustained requests give one grant per 2 cycles when each owner releases immediately.
- Reset asserted mid-grant drops gnt to 8'h00 without waiting for a clock edge.
- After reset deasserts, the first arbitration starts from ptr=0.
- Hold count:
  - The first GRANT cycle is count 0.
  - The forced release takes effect at the edge ending count MAX_HOLD-1, so the grant lasts exactly MAX_HOLD cycles.

## Configuration
- Macro: RR_TIMEOUT_EN.
- Defined:
  - The hold counter (8 bits) is present.
  - If the owner has not released by the end of the MAX_HOLD-th GRANT cycle: gnt_en falls, ptr advances past the owner, and timeout=1 for exactly the one cycle in which gnt_en first reads 0.
  - If done arrives in the same cycle the limit expires, it is a normal release with timeout=0.
- Undefined:
  - No counter.
  - timeout is tied to 0.
  - A grant is held indefinitely until done or withdrawal.

## Test plan
- Idle: after reset, req=8'h00 for 10 cycles → gnt=8'h00, gnt_en=0, timeout=0 throughout.
- Basic: from reset, req=8'b0010_0100 → gnt_idx=2, gnt=8'h04 one cycle later. Pulse done → gnt=8'h00 for one cycle, then gnt_idx=5, gnt=8'h20.
- Fairness: req=8'hFF held, done pulsed on every grant's first cycle → grant order 0,1,2,...,7,0,1 with one zero cycle between each.
- Wrap/withdraw: after grant 5 releases (ptr=6), req=8'b0000_0011 → gnt=8'h01. Then drop req[0] → gnt=8'h00 next cycle, then gnt=8'h02.
- Timeout (RR_TIMEOUT_EN, MAX_HOLD=4): req=8'h08 held, no done → gnt=8'h08 for exactly 4 cycles, timeout=1 for 1 cycle, then gnt=8'h08 re-granted after the gap.
- Async reset: rst pulsed mid-cycle while gnt=8'h10 → gnt=8'h00 immediately. With req=8'h10 still held after release → gnt=8'h10 one cycle after the first post-reset edge.
